regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port (reg_W_addr / wdata / reg_we) among NREQ writeback requesters, e.g. ALU result, load data and link-address writeback in the multi-cycle CPU. Uses a valid/ready handshake per requester and round-robin arbitration, and drives the register-file write port from registers. Sits between the writeback sources and the register file.

---
 rtl/regfile_wb_arbiter_if.sv | 25 ++
 rtl/regfile_wb_arbiter.sv | 77 +++++++
 tb/tb_regfile_wb_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: NREQ requesters, each with valid/addr/data, plus the one-hot ready strobe.
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NREQ writeback sources.
// The write port is registered; writes to r0 are accepted but turned into a one-cycle drop pulse.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  req,
    input  logic                 hold,
    output logic                 reg_we,
    output logic [AW-1:0]        reg_W_addr,
    output logic [DW-1:0]        wdata,
    output logic [IDW-1:0]       grant_id,
    output logic                 drop
);

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  win;
    logic            found;
    logic            xfer;
    logic [NREQ-1:0] ready_vec;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;
    int              idx;

    // First valid requester at or after ptr, wrapping, wins the port this cycle.
    always_comb begin
        found     = 1'b0;
        win       = '0;
        idx       = 0;
        ready_vec = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req.req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
        xfer = found && !hold && !rst;
        if (xfer) begin
            ready_vec[int'(win)] = 1'b1;
        end
        win_addr = req.req_addr[int'(win)*AW +: AW];
        win_data = req.req_data[int'(win)*DW +: DW];
    end

    assign req.req_ready = ready_vec;

    // Address/data/id hold their last value between transfers; only we/drop are pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_we     <= 1'b0;
            reg_W_addr <= '0;
            wdata      <= '0;
            grant_id   <= '0;
            drop       <= 1'b0;
            ptr        <= '0;
        end else if (xfer) begin
            grant_id   <= win;
            reg_W_addr <= win_addr;
            wdata      <= win_data;
            reg_we     <= (win_addr != '0);
            drop       <= (win_addr == '0);
            ptr        <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
        end else begin
            reg_we <= 1'b0;
            drop   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: stimulus pushes expected writes into a queue,
// a negedge monitor pops and compares whenever the write port shows reg_we or drop.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int IDW  = 2;

    typedef struct {
        logic [IDW-1:0] gid;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic           we;
        logic           drp;
    } wb_item_t;

    logic           clk;
    logic           rst;
    logic           hold;
    logic           reg_we;
    logic [AW-1:0]  reg_W_addr;
    logic [DW-1:0]  wdata;
    logic [IDW-1:0] grant_id;
    logic           drop;

    int checks;
    int errors;
    wb_item_t exp_q[$];
    logic [DW-1:0] rf [32];

    regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) req_bus ();

    regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req_bus.slave),
        .hold       (hold),
        .reg_we     (reg_we),
        .reg_W_addr (reg_W_addr),
        .wdata      (wdata),
        .grant_id   (grant_id),
        .drop       (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model fed by the write port; no reset, so lost writes stay visible as absent.
    always @(posedge clk) begin
        if (reg_we) begin
            rf[reg_W_addr] <= wdata;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: any visible write or drop must match the oldest expected transfer.
    always @(negedge clk) begin
        if (!rst && (reg_we || drop)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got gid=%0d addr=%0d data=%h we=%b drop=%b, none expected",
                         grant_id, reg_W_addr, wdata, reg_we, drop);
            end else begin
                wb_item_t e;
                e = exp_q.pop_front();
                if (grant_id !== e.gid || reg_W_addr !== e.addr || wdata !== e.data ||
                    reg_we !== e.we || drop !== e.drp) begin
                    errors++;
                    $display("[TB] FAIL write_port: got gid=%0d addr=%0d data=%h we=%b drop=%b, expected gid=%0d addr=%0d data=%h we=%b drop=%b",
                             grant_id, reg_W_addr, wdata, reg_we, drop,
                             e.gid, e.addr, e.data, e.we, e.drp);
                end
            end
        end
    end

    // Drive one cycle from a negedge, check ready, queue the expected write, return at the next negedge.
    task automatic apply_stimulus(input logic [2:0] v,
                                  input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                  input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                  input logic h, input logic [2:0] exp_ready);
        wb_item_t e;
        logic [AW-1:0] a_sel;
        logic [DW-1:0] d_sel;
        req_bus.req_valid = v;
        req_bus.req_addr  = {a2, a1, a0};
        req_bus.req_data  = {d2, d1, d0};
        hold = h;
        #1;
        check_output("req_ready", 32'(req_bus.req_ready), 32'(exp_ready));
        if (exp_ready != 3'b000) begin
            case (exp_ready)
                3'b001:  begin e.gid = 2'd0; a_sel = a0; d_sel = d0; end
                3'b010:  begin e.gid = 2'd1; a_sel = a1; d_sel = d1; end
                default: begin e.gid = 2'd2; a_sel = a2; d_sel = d2; end
            endcase
            e.addr = a_sel;
            e.data = d_sel;
            e.we   = (a_sel != '0);
            e.drp  = (a_sel == '0);
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        hold = 1'b0;
        req_bus.req_valid = 3'b111;
        req_bus.req_addr  = {5'd3, 5'd2, 5'd1};
        req_bus.req_data  = '0;
        #1;
        check_output("rst_ready", 32'(req_bus.req_ready), 32'd0);
        check_output("rst_we", 32'(reg_we), 32'd0);
        check_output("rst_addr", 32'(reg_W_addr), 32'd0);
        check_output("rst_wdata", wdata, 32'd0);
        check_output("rst_gid", 32'(grant_id), 32'd0);
        check_output("rst_drop", 32'(drop), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] fairness with all requesters valid");
        apply_stimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'hA000_0001, 32'hB000_0001, 32'hC000_0001, 1'b0, 3'b001);
        apply_stimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'hA000_0002, 32'hB000_0001, 32'hC000_0001, 1'b0, 3'b010);
        apply_stimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'hA000_0002, 32'hB000_0002, 32'hC000_0001, 1'b0, 3'b100);
        apply_stimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'hA000_0002, 32'hB000_0002, 32'hC000_0002, 1'b0, 3'b001);
        apply_stimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'hA000_0003, 32'hB000_0002, 32'hC000_0002, 1'b0, 3'b010);
        apply_stimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'hA000_0003, 32'hB000_0003, 32'hC000_0002, 1'b0, 3'b100);
        apply_stimulus(3'b100, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'hC000_0010, 1'b0, 3'b100);
        apply_stimulus(3'b100, 5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 32'hC000_0011, 1'b0, 3'b100);

        $display("[TB] single write to r5");
        apply_stimulus(3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 3'b010);
        apply_stimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000);
        check_output("idle_we", 32'(reg_we), 32'd0);
        check_output("rf_r5", rf[5], 32'hDEAD_BEEF);

        $display("[TB] write to r0 is dropped");
        apply_stimulus(3'b100, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0000_1234, 1'b0, 3'b100);
        apply_stimulus(3'b001, 5'd4, 5'd0, 5'd0, 32'h4444_0000, 32'h0, 32'h0, 1'b0, 3'b001);

        $display("[TB] hold freezes arbitration");
        apply_stimulus(3'b011, 5'd6, 5'd10, 5'd0, 32'h6666_0000, 32'hAAAA_0000, 32'h0, 1'b1, 3'b000);
        apply_stimulus(3'b011, 5'd6, 5'd10, 5'd0, 32'h6666_0000, 32'hAAAA_0000, 32'h0, 1'b1, 3'b000);
        check_output("hold_we", 32'(reg_we), 32'd0);
        apply_stimulus(3'b011, 5'd6, 5'd10, 5'd0, 32'h6666_0000, 32'hAAAA_0000, 32'h0, 1'b1, 3'b000);
        check_output("hold_we_end", 32'(reg_we), 32'd0);
        apply_stimulus(3'b011, 5'd6, 5'd10, 5'd0, 32'h6666_0000, 32'hAAAA_0000, 32'h0, 1'b0, 3'b010);
        apply_stimulus(3'b001, 5'd6, 5'd0, 5'd0, 32'h6666_0000, 32'h0, 32'h0, 1'b0, 3'b001);

        $display("[TB] asynchronous reset during a pending write");
        apply_stimulus(3'b001, 5'd9, 5'd0, 5'd0, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b0, 3'b001);
        check_output("pre_rst_we", 32'(reg_we), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_output("async_rst_we", 32'(reg_we), 32'd0);
        check_output("async_rst_ready", 32'(req_bus.req_ready), 32'd0);
        @(negedge clk);
        check_output("rf_r9_lost", 32'(rf[9] === 32'hCAFE_F00D), 32'd0);
        rst = 1'b0;
        apply_stimulus(3'b111, 5'd11, 5'd12, 5'd13, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 1'b0, 3'b001);
        apply_stimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000);
        @(negedge clk);
        check_output("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
